// File: rtl/ppu_reg_shadow_sched.sv
// PPU shadow-register scheduler: snoops B-bus writes and applies them to the RGB datapath config.
// Ports: mclock/reset, pawr_n/paddress/pdata bus snoop, hblank/vblank window inputs,
//   the applied shadow flags, pending_cnt (queue occupancy) and overflow (sticky drop flag).
// Build option: define PPU_SHADOW_IMMEDIATE_EN to bypass the queue and apply writes directly.
module ppu_reg_shadow_sched #(
  parameter logic [7:0] ADDR_INIDISP = 8'h00,
  parameter logic [7:0] ADDR_BGMODE  = 8'h05,
  parameter logic [7:0] ADDR_M7SEL   = 8'h1A,
  parameter logic [7:0] ADDR_SETINI  = 8'h33,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic                        mclock,
  input  logic                        reset,
  input  logic                        pawr_n,
  input  logic [7:0]                  paddress,
  input  logic [7:0]                  pdata,
  input  logic                        hblank,
  input  logic                        vblank,
  output logic [3:0]                  brightness,
  output logic                        force_blank,
  output logic                        mode7,
  output logic                        mode56,
  output logic                        mode01234,
  output logic                        pseudohires,
  output logic                        screen_over,
  output logic                        over,
  output logic                        hires_sel,
  output logic [$clog2(FIFO_DEPTH):0] pending_cnt,
  output logic                        overflow
);

  logic [2:0] s_q;
  logic [7:0] a1_q, a2_q, a3_q;
  logic [7:0] d1_q, d2_q, d3_q;

  // Strobe pipeline presets high so reset release never looks like a write end.
  always_ff @(posedge mclock or posedge reset) begin
    if (reset) begin
      s_q  <= 3'b111;
      a1_q <= '0;
      a2_q <= '0;
      a3_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
    end else begin
      s_q  <= {s_q[1:0], pawr_n};
      a1_q <= paddress;
      a2_q <= a1_q;
      a3_q <= a2_q;
      d1_q <= pdata;
      d2_q <= d1_q;
      d3_q <= d2_q;
    end
  end

  // s_q[1] is s2, s_q[2] is s3; a3/d3 line up with the last low-strobe sample.
  logic       wr_end;
  logic       hit;
  logic [1:0] sel;
  logic       push_req;

  assign wr_end = s_q[1] & ~s_q[2];

  always_comb begin
    hit = 1'b1;
    sel = 2'd0;
    if (a3_q == ADDR_INIDISP)     sel = 2'd0;
    else if (a3_q == ADDR_BGMODE) sel = 2'd1;
    else if (a3_q == ADDR_M7SEL)  sel = 2'd2;
    else if (a3_q == ADDR_SETINI) sel = 2'd3;
    else                          hit = 1'b0;
  end

  assign push_req = wr_end & hit;

  logic       apply_v;
  logic [9:0] apply_e;

  logic [3:0] bright_q, bright_d;
  logic       fb_q, fb_d;
  logic       m7_q, m7_d;
  logic       m56_q, m56_d;
  logic       m01234_q, m01234_d;
  logic       ph_q, ph_d;
  logic       so_q, so_d;
  logic       over_q, over_d;
  logic       hs_q, hs_d;

`ifdef PPU_SHADOW_IMMEDIATE_EN
  logic unused_win;

  assign unused_win  = ^{hblank, vblank};
  assign apply_v     = push_req;
  assign apply_e     = {sel, d3_q};
  assign pending_cnt = '0;
  assign overflow    = 1'b0;
`else
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [1:0]    hb_q, vb_q;
  logic          win;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q;
  logic [9:0]    mem_q [FIFO_DEPTH];

  always_ff @(posedge mclock or posedge reset) begin
    if (reset) begin
      hb_q <= '0;
      vb_q <= '0;
    end else begin
      hb_q <= {hb_q[0], hblank};
      vb_q <= {vb_q[0], vblank};
    end
  end

  assign win  = hb_q[1] | vb_q[1] | fb_q;
  assign pop  = win & (cnt_q != '0);
  assign full = (cnt_q == CW'(FIFO_DEPTH));
  // A full queue still accepts a write when an entry leaves on the same edge.
  assign push_ok = push_req & (~full | pop);
  assign cnt_d   = cnt_q + CW'(push_ok) - CW'(pop);

  always_ff @(posedge mclock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
      if (push_req & ~push_ok) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge mclock) begin
    if (push_ok) mem_q[wr_q] <= {sel, d3_q};
  end

  assign apply_v     = pop;
  assign apply_e     = mem_q[rd_q];
  assign pending_cnt = cnt_q;
  assign overflow    = ovf_q;
`endif

  always_comb begin
    bright_d = bright_q;
    fb_d     = fb_q;
    m7_d     = m7_q;
    m56_d    = m56_q;
    m01234_d = m01234_q;
    ph_d     = ph_q;
    so_d     = so_q;
    if (apply_v) begin
      unique case (apply_e[9:8])
        2'd0: begin
          bright_d = apply_e[3:0];
          fb_d     = apply_e[7];
        end
        2'd1: begin
          m7_d     = (apply_e[2:0] == 3'd7);
          m56_d    = (apply_e[2:0] == 3'd5) | (apply_e[2:0] == 3'd6);
          m01234_d = (apply_e[2:0] <= 3'd4);
        end
        2'd2: so_d = (apply_e[7:6] == 2'b10);
        2'd3: ph_d = apply_e[3];
      endcase
    end
    // Derived flags follow their sources on the same edge.
    over_d = m7_d & so_d;
    hs_d   = m56_d | (ph_d & m01234_d);
  end

  always_ff @(posedge mclock or posedge reset) begin
    if (reset) begin
      bright_q <= 4'hF;
      fb_q     <= 1'b0;
      m7_q     <= 1'b0;
      m56_q    <= 1'b0;
      m01234_q <= 1'b0;
      ph_q     <= 1'b0;
      so_q     <= 1'b0;
      over_q   <= 1'b0;
      hs_q     <= 1'b0;
    end else begin
      bright_q <= bright_d;
      fb_q     <= fb_d;
      m7_q     <= m7_d;
      m56_q    <= m56_d;
      m01234_q <= m01234_d;
      ph_q     <= ph_d;
      so_q     <= so_d;
      over_q   <= over_d;
      hs_q     <= hs_d;
    end
  end

  assign brightness  = bright_q;
  assign force_blank = fb_q;
  assign mode7       = m7_q;
  assign mode56      = m56_q;
  assign mode01234   = m01234_q;
  assign pseudohires = ph_q;
  assign screen_over = so_q;
  assign over        = over_q;
  assign hires_sel   = hs_q;

endmodule
